// File: rtl/gate_vector_checker.sv
// gate_vector_checker
//   Built-in self-test engine for a 2-input AND gate. It drives the gate inputs through
//   00, 01, 10 and 11, holding each vector for STEP_CYCLES clocks. On the last hold cycle
//   of each vector it samples the gate output and compares it with a&b. It counts
//   mismatches and remembers the most recent failing vector.
//
//   Optional feature: define GVC_CONTINUOUS_EN to loop over the vectors forever. In that
//   mode DONE is never entered and err_count accumulates across passes. Only rst stops it.
//
// Parameters
//   STEP_CYCLES   clocks each vector is held (>= 2)
//   ERR_W         width of the saturating mismatch counter
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   start          in   1-cycle pulse, honoured only in IDLE or DONE
//   a, b           out  gate inputs (registered)
//   dut_out        in   gate output, combinational from a,b
//   busy           out  1 while vectors are being driven
//   done           out  1 after a completed run, until the next start or rst
//   pass           out  1 when done and no mismatches were seen
//   err_count      out  mismatches in the current/last run, saturating
//   last_fail_vec  out  {a,b} of the most recent mismatching vector, 00 if none

module gate_vector_checker #(
    parameter int unsigned STEP_CYCLES = 5,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       last_fail_vec
);

    localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StDone
    } state_t;

    state_t           state;
    logic [1:0]       vec;
    logic [CNT_W-1:0] step_cnt;

    logic sample;
    logic mismatch;
    logic err_sat;

    always_comb begin
        sample   = (state == StDrive) && (step_cnt == LAST_STEP);
        mismatch = (dut_out != (a & b));
        err_sat  = &err_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            vec           <= 2'b00;
            step_cnt      <= '0;
            a             <= 1'b0;
            b             <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            last_fail_vec <= 2'b00;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state         <= StDrive;
                        vec           <= 2'b00;
                        step_cnt      <= '0;
                        {a, b}        <= 2'b00;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_count     <= '0;
                        last_fail_vec <= 2'b00;
                    end
                end
                StDrive: begin
                    if (sample) begin
                        if (mismatch) begin
                            if (!err_sat) begin
                                err_count <= err_count + 1'b1;
                            end
                            last_fail_vec <= {a, b};
                        end
                        step_cnt <= '0;
                        vec      <= vec + 2'd1;
                        if (vec == 2'd3) begin
`ifdef GVC_CONTINUOUS_EN
                            // Wrap back to vector 00 and keep going.
                            {a, b} <= 2'b00;
`else
                            // a,b keep 11; pass must include this final sample.
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= !mismatch && (err_count == '0);
`endif
                        end else begin
                            {a, b} <= vec + 2'd1;
                        end
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker. A behavioural gate model selectable between
// good AND, stuck-at-0, stuck-at-1 and NAND feeds the main instance. A second instance
// with ERR_W=2 and a NAND gate exercises counter saturation.

module tb_gate_vector_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       a, b, dut_out, busy, done, pass;
    logic [7:0] err_count;
    logic [1:0] last_fail_vec;

    logic       a2, b2, dut_out2, busy2, done2, pass2;
    logic [1:0] err_count2;
    logic [1:0] last_fail_vec2;

    int mode;        // 0 good AND, 1 stuck-at-0, 2 stuck-at-1, 3 NAND
    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            0:       dut_out = a & b;
            1:       dut_out = 1'b0;
            2:       dut_out = 1'b1;
            default: dut_out = ~(a & b);
        endcase
    end

    always_comb dut_out2 = ~(a2 & b2);

    gate_vector_checker #(
        .STEP_CYCLES(5),
        .ERR_W      (8)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a            (a),
        .b            (b),
        .dut_out      (dut_out),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .last_fail_vec(last_fail_vec)
    );

    gate_vector_checker #(
        .STEP_CYCLES(2),
        .ERR_W      (2)
    ) u_sat (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a            (a2),
        .b            (b2),
        .dut_out      (dut_out2),
        .busy         (busy2),
        .done         (done2),
        .pass         (pass2),
        .err_count    (err_count2),
        .last_fail_vec(last_fail_vec2)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    // Start is sampled on "edge 0"; afterwards the bench is in cycle 1.
    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ab"},   {30'd0, a, b}, 32'd0);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " pass"}, {31'd0, pass}, 32'd0);
        check({tag, " err"},  {24'd0, err_count}, 32'd0);
        check({tag, " lfv"},  {30'd0, last_fail_vec}, 32'd0);
    endtask

    task automatic check_result(input string tag, input logic exp_pass, input int exp_err,
                                input logic [1:0] exp_lfv);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " pass"}, {31'd0, pass}, {31'd0, exp_pass});
        check({tag, " err"},  {24'd0, err_count}, exp_err);
        check({tag, " lfv"},  {30'd0, last_fail_vec}, {30'd0, exp_lfv});
        check({tag, " ab"},   {30'd0, a, b}, 32'd3);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");

`ifdef GVC_CONTINUOUS_EN
        // NAND gate mismatches on every vector; the loop never stops.
        mode = 3;
        start_run();
        wait_cyc(21);
        check("cont ab wrap", {30'd0, a, b}, 32'd0);
        check("cont busy",    {31'd0, busy}, 32'd1);
        check("cont done",    {31'd0, done}, 32'd0);
        check("cont err 1",   {24'd0, err_count}, 32'd4);
        wait_cyc(41);
        check("cont err 2",   {24'd0, err_count}, 32'd8);
        check("cont lfv",     {30'd0, last_fail_vec}, 32'd3);
        check("cont pass",    {31'd0, pass}, 32'd0);
        check("sat err",      {30'd0, err_count2}, 32'd3);
        check("sat busy",     {31'd0, busy2}, 32'd1);
        check("sat done",     {31'd0, done2}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("cont rst");
`else
        // Good gate: vector timing and clean result.
        mode = 0;
        start_run();
        check("good ab c1",    {30'd0, a, b}, 32'd0);
        check("good busy c1",  {31'd0, busy}, 32'd1);
        wait_cyc(5);
        check("good ab c5",    {30'd0, a, b}, 32'd0);
        wait_cyc(6);
        check("good ab c6",    {30'd0, a, b}, 32'd1);
        wait_cyc(11);
        check("good ab c11",   {30'd0, a, b}, 32'd2);
        wait_cyc(16);
        check("good ab c16",   {30'd0, a, b}, 32'd3);
        wait_cyc(20);
        check("good done c20", {31'd0, done}, 32'd0);
        check("good busy c20", {31'd0, busy}, 32'd1);
        wait_cyc(21);
        check_result("good", 1'b1, 0, 2'b00);
        // NAND with 2-bit counter: four mismatches saturate at 3.
        check("sat err",  {30'd0, err_count2}, 32'd3);
        check("sat lfv",  {30'd0, last_fail_vec2}, 32'd3);
        check("sat done", {31'd0, done2}, 32'd1);
        check("sat pass", {31'd0, pass2}, 32'd0);

        mode = 1;
        start_run();
        wait_cyc(20);
        check("s0 err c20", {24'd0, err_count}, 32'd0);
        wait_cyc(21);
        check_result("s0", 1'b0, 1, 2'b11);

        mode = 2;
        start_run();
        wait_cyc(21);
        check_result("s1", 1'b0, 3, 2'b10);

        mode = 3;
        start_run();
        wait_cyc(21);
        check_result("nand", 1'b0, 4, 2'b11);

        // Re-run with good gate: results cleared on start.
        mode = 0;
        start_run();
        check("rerun err c1", {24'd0, err_count}, 32'd0);
        check("rerun lfv c1", {30'd0, last_fail_vec}, 32'd0);
        check("rerun done c1", {31'd0, done}, 32'd0);
        // Extra start sampled on edge 8 must be ignored.
        wait_cyc(8);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("xstart ab c9",  {30'd0, a, b}, 32'd1);
        wait_cyc(11);
        check("xstart ab c11", {30'd0, a, b}, 32'd2);
        wait_cyc(20);
        check("xstart done c20", {31'd0, done}, 32'd0);
        wait_cyc(21);
        check_result("rerun", 1'b1, 0, 2'b00);

        // Abort mid-run with rst on edge 12.
        mode = 2;
        start_run();
        wait_cyc(12);
        check("abort err c12", {24'd0, err_count}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("abort");
        tick();
        tick();
        check_idle("abort idle");
        // rst and start together: rst wins.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst+start busy", {31'd0, busy}, 32'd0);
        start_run();
        wait_cyc(21);
        check_result("fresh", 1'b0, 3, 2'b10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
